// File: rtl/lsu_dm_bridge_if.sv
// Signal bundle between the MEM-stage requester, the lsu_dm_bridge and the data memory.
// The master side is the environment (pipeline plus DM model); the slave side is the bridge.
interface lsu_dm_bridge_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic [2:0]        dm_type;
  logic [31:0]       dm_dout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, dm_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_din, dm_type
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, dm_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_din, dm_type
  );
endinterface

// File: rtl/lsu_dm_bridge.sv
// Load/store sequencer between the MEM-stage request and a byte-addressed data memory.
// Aligned accesses take one DM beat; misaligned half/word accesses are split into byte beats.
module lsu_dm_bridge #(
  parameter int ADDR_W           = 6,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  lsu_dm_bridge_if.slave    bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_SPLIT  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] dm_type_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b011;
      2'b01:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Bits above the access size are discarded before extension.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b010:  return d;
      3'b100:  return {24'h00_0000, d[7:0]};
      3'b101:  return {16'h0000, d[15:0]};
      default: return 32'h0000_0000;
    endcase
  endfunction

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       rbuf_d;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       dm_din_q;
  logic [2:0]        dm_type_q;
  logic              busy_q;
  logic [1:0]        k_nxt_s;
  logic [7:0]        wbyte_nxt_s;
  logic              last_beat_s;
  logic              req_bad_s;
  logic              req_mis_s;
  logic              unused_s;

  // Beat bookkeeping for the split path and request classification.
  always_comb begin
    rbuf_d                  = rbuf_q;
    rbuf_d[{k_q, 3'b000} +: 8] = bus.dm_dout[7:0];
    k_nxt_s                 = k_q + 2'd1;
    wbyte_nxt_s             = wdata_q[{k_nxt_s, 3'b000} +: 8];
    last_beat_s             = (f3_q[1:0] == 2'b01) ? (k_q == 2'd1) : (k_q == 2'd3);
    req_bad_s               = is_illegal(bus.req_we, bus.req_funct3);
    req_mis_s               = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  end

  assign unused_s = ^bus.req_addr[31:ADDR_W];

  // Sequencer FSM; every output to the requester and DM is a register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      k_q          <= 2'd0;
      rbuf_q       <= 32'h0000_0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_din_q     <= 32'h0000_0000;
      dm_type_q    <= 3'b000;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            addr_q      <= bus.req_addr[ADDR_W-1:0];
            wdata_q     <= bus.req_wdata;
            k_q         <= 2'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_bad_s || (req_mis_s && !SPLIT_MISALIGNED)) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else if (req_mis_s) begin
              state_q   <= S_SPLIT;
              dm_we_q   <= bus.req_we;
              dm_addr_q <= bus.req_addr[ADDR_W-1:0];
              dm_type_q <= 3'b011;
              dm_din_q  <= {24'h00_0000, bus.req_wdata[7:0]};
            end else begin
              state_q   <= S_ACCESS;
              dm_we_q   <= bus.req_we;
              dm_addr_q <= bus.req_addr[ADDR_W-1:0];
              dm_type_q <= dm_type_of(bus.req_funct3[1:0]);
              dm_din_q  <= bus.req_wdata;
            end
          end
        end
        S_ACCESS: begin
          state_q      <= S_RESP;
          dm_we_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'h0000_0000 : load_ext(f3_q, bus.dm_dout);
        end
        S_SPLIT: begin
          rbuf_q <= rbuf_d;
          if (last_beat_s) begin
            state_q      <= S_RESP;
            dm_we_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'h0000_0000 : load_ext(f3_q, rbuf_d);
          end else begin
            k_q       <= k_nxt_s;
            dm_addr_q <= addr_q + ADDR_W'(k_nxt_s);
            dm_din_q  <= {24'h00_0000, wbyte_nxt_s};
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          dm_we_q      <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.dm_we      = dm_we_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_din     = dm_din_q;
  assign bus.dm_type    = dm_type_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lsu_dm_bridge.sv
// Self-checking bench for lsu_dm_bridge: byte-array DM model, reference memory and response scoreboard.
module tb_lsu_dm_bridge;
  localparam int AW = 6;

  logic clk       = 1'b0;
  logic rstn      = 1'b0;
  logic mem_ready = 1'b0;
  logic busy;
  logic busy2;

  always #5 clk = ~clk;

  lsu_dm_bridge_if #(.ADDR_W(AW)) bus ();
  lsu_dm_bridge_if #(.ADDR_W(AW)) bus2 ();

  lsu_dm_bridge #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy)
  );
  lsu_dm_bridge #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rstn(rstn), .bus(bus2), .busy(busy2)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [2:0]    typ;
    logic [31:0]   din;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic [7:0] mem     [64];
  logic [7:0] ref_mem [64];
  beat_t      beat_q  [$];
  exp_t       sb_q    [$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         ns_we_cnt = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [5:0] wrap(input logic [5:0] a, input int k);
    return a + 6'(k);
  endfunction

  function automatic int n_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_bad(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 >= 3'b110) || (we && (f3 >= 3'b100));
  endfunction

  function automatic logic misal(input logic [2:0] f3, input logic [5:0] a);
    return (n_bytes(f3) == 2 && a[0]) || (n_bytes(f3) == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [5:0] a);
    logic [31:0] raw;
    raw = 32'h0;
    for (int k = 0; k < n_bytes(f3); k++) raw[8*k +: 8] = ref_mem[wrap(a, k)];
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // DM model: combinational little-endian read of four bytes, sized write at the clock edge.
  always_comb begin
    bus.dm_dout = {mem[wrap(bus.dm_addr, 3)], mem[wrap(bus.dm_addr, 2)],
                   mem[wrap(bus.dm_addr, 1)], mem[bus.dm_addr]};
  end
  assign bus2.dm_dout = 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
    end else if (bus.dm_we) begin
      mem[bus.dm_addr] <= bus.dm_din[7:0];
      if (bus.dm_type != 3'b011) mem[wrap(bus.dm_addr, 1)] <= bus.dm_din[15:8];
      if (bus.dm_type == 3'b000) begin
        mem[wrap(bus.dm_addr, 2)] <= bus.dm_din[23:16];
        mem[wrap(bus.dm_addr, 3)] <= bus.dm_din[31:24];
      end
    end
  end

  // Beat log: one entry per DM beat cycle (busy but no response pending).
  always @(posedge clk) begin
    if (rstn && busy && !bus.resp_valid)
      beat_q.push_back({bus.dm_we, bus.dm_addr, bus.dm_type, bus.dm_din});
  end

  always @(posedge clk) begin
    if (bus2.dm_we) ns_we_cnt <= ns_we_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [5:0] a, input logic [31:0] wd, input int hold);
    exp_t  e;
    beat_t b;
    int    exp_lat, exp_beats, lat, b0, nb;
    logic  bad, mis;
    bad       = is_bad(w, f3);
    mis       = misal(f3, a);
    nb        = n_bytes(f3);
    exp_lat   = bad ? 1 : (mis ? nb + 1 : 2);
    exp_beats = bad ? 0 : (mis ? nb : 1);
    e.err     = bad;
    e.rdata   = (bad || w) ? 32'h0 : exp_load(f3, a);
    if (!bad && w) begin
      for (int k = 0; k < nb; k++) ref_mem[wrap(a, k)] = wd[8*k +: 8];
    end
    sb_q.push_back(e);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = w;
    bus.req_funct3 = f3;
    bus.req_addr   = {26'($urandom()), a};
    bus.req_wdata  = wd;
    bus.resp_ready = (hold == 0);
    lat = 0;
    while (!bus.req_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.req_ready) check_val($sformatf("%s_accept_timeout", tag), 32'd0, 32'd1);
    @(posedge clk);
    b0 = beat_q.size();
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    check_val($sformatf("%s_beats", tag), 32'(beat_q.size() - b0), 32'(exp_beats));
    for (int i = b0; i < beat_q.size(); i++) begin
      b = beat_q[i];
      check_val($sformatf("%s_beat%0d_we", tag, i - b0), 32'(b.we), 32'(w));
      check_val($sformatf("%s_beat%0d_addr", tag, i - b0), 32'(b.addr), 32'(wrap(a, i - b0)));
      check_val($sformatf("%s_beat%0d_type", tag, i - b0), 32'(b.typ),
                mis ? 32'd3 : (nb == 1 ? 32'd3 : (nb == 2 ? 32'd1 : 32'd0)));
      check_val($sformatf("%s_beat%0d_din", tag, i - b0), b.din,
                mis ? {24'h0, wd[8*(i-b0) +: 8]} : wd);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val($sformatf("%s_rdata", tag), bus.resp_rdata, e.rdata);
      check_val($sformatf("%s_err", tag), 32'(bus.resp_err), 32'(e.err));
    end
    b0 = beat_q.size();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val($sformatf("%s_hold_valid", tag), 32'(bus.resp_valid), 32'd1);
      check_val($sformatf("%s_hold_rdata", tag), bus.resp_rdata, e.rdata);
      check_val($sformatf("%s_hold_err", tag), 32'(bus.resp_err), 32'(e.err));
      check_val($sformatf("%s_hold_dm_we", tag), 32'(bus.dm_we), 32'd0);
    end
    check_val($sformatf("%s_hold_beats", tag), 32'(beat_q.size() - b0), 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.req_valid   = 1'b0;  bus.req_we   = 1'b0;  bus.req_funct3 = 3'b000;
    bus.req_addr    = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    bus2.req_valid  = 1'b0;  bus2.req_we  = 1'b0;  bus2.req_funct3 = 3'b000;
    bus2.req_addr   = 32'h0; bus2.req_wdata = 32'h0; bus2.resp_ready = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check_val("rst_resp_err",   32'(bus.resp_err),   32'd0);
    check_val("rst_dm_we",      32'(bus.dm_we),      32'd0);
    check_val("rst_dm_addr",    32'(bus.dm_addr),    32'd0);
    check_val("rst_dm_din",     bus.dm_din,          32'd0);
    check_val("rst_dm_type",    32'(bus.dm_type),    32'd0);
    check_val("rst_busy",       32'(busy),           32'd0);
    rstn = 1'b1;

    do_req("sw08",  1'b1, 3'b010, 6'h08, 32'h8765_4321, 0);
    do_req("lw08",  1'b0, 3'b010, 6'h08, 32'h0, 0);
    do_req("sb05",  1'b1, 3'b000, 6'h05, 32'h1234_56F0, 0);
    do_req("lb05",  1'b0, 3'b000, 6'h05, 32'h0, 0);
    do_req("lbu05", 1'b0, 3'b100, 6'h05, 32'h0, 0);
    check_val("mem04_unchanged", 32'(mem[4]), 32'(init_byte(4)));
    check_val("mem06_unchanged", 32'(mem[6]), 32'(init_byte(6)));
    do_req("lh04",  1'b0, 3'b001, 6'h04, 32'h0, 0);
    do_req("lhu04", 1'b0, 3'b101, 6'h04, 32'h0, 0);
    do_req("sw03",  1'b1, 3'b010, 6'h03, 32'hAABB_CCDD, 0);
    do_req("lw03",  1'b0, 3'b010, 6'h03, 32'h0, 0);
    do_req("sb3f",  1'b1, 3'b000, 6'h3F, 32'h0000_0080, 0);
    do_req("sb00",  1'b1, 3'b000, 6'h00, 32'h0000_0001, 0);
    do_req("lh3f",  1'b0, 3'b001, 6'h3F, 32'h0, 0);
    do_req("lw3e",  1'b0, 3'b010, 6'h3E, 32'h0, 0);
    do_req("sh11",  1'b1, 3'b001, 6'h11, 32'h5555_BEEF, 0);
    do_req("lhu11", 1'b0, 3'b101, 6'h11, 32'h0, 0);
    do_req("lh11",  1'b0, 3'b001, 6'h11, 32'h0, 0);
    do_req("ill_ld", 1'b0, 3'b011, 6'h10, 32'h0, 0);
    do_req("ill_st", 1'b1, 3'b100, 6'h10, 32'hFFFF_FFFF, 0);
    do_req("bp_lw08", 1'b0, 3'b010, 6'h08, 32'h0, 5);
    for (int i = 0; i < 64; i++) check_val($sformatf("mem%02h", i), 32'(mem[i]), 32'(ref_mem[i]));

    // Non-splitting instance: misaligned lh returns an error without touching the DM.
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    check_val("ns_req_ready", 32'(bus2.req_ready), 32'd1);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b001; bus2.req_addr = 32'h0000_003F;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    check_val("ns_resp_valid", 32'(bus2.resp_valid), 32'd1);
    e = sb_q.pop_front();
    check_val("ns_rdata", bus2.resp_rdata, e.rdata);
    check_val("ns_err", 32'(bus2.resp_err), 32'(e.err));
    @(posedge clk);
    @(negedge clk);
    check_val("ns_dm_we_count", 32'(ns_we_cnt), 32'd0);

    // Reset during the third byte beat of a split store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr  = 32'h0000_0021; bus.req_wdata = 32'h4433_2211; bus.resp_ready = 1'b1;
    check_val("rsplit_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("rsplit_we_before", 32'(bus.dm_we), 32'd1);
    check_val("rsplit_addr_before", 32'(bus.dm_addr), 32'h23);
    #1 rstn = 1'b0;
    #1;
    check_val("rsplit_dm_we",      32'(bus.dm_we),      32'd0);
    check_val("rsplit_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rsplit_req_ready",  32'(bus.req_ready),  32'd1);
    check_val("rsplit_busy",       32'(busy),           32'd0);
    ref_mem[6'h21] = 8'h11;
    ref_mem[6'h22] = 8'h22;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rsplit_ready_after", 32'(bus.req_ready),  32'd1);
    check_val("rsplit_valid_after", 32'(bus.resp_valid), 32'd0);
    for (int i = 6'h21; i <= 6'h24; i++)
      check_val($sformatf("rsplit_mem%02h", i), 32'(mem[i]), 32'(ref_mem[i]));
    do_req("lw20_after_rst", 1'b0, 3'b010, 6'h20, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_dm_bridge.md
Name: lsu_dm_bridge

Overview:
- Load/store sequencing stage between the MEM-stage pipeline request and the byte-addressed data memory (DMWr/addr/din/DMType/dout port).
- Accepts one RISC-V load/store per valid/ready handshake and drives the DM port.
- Aligned accesses complete as a single DM beat. Misaligned halfword/word accesses are split into byte beats.
- Returns sign- or zero-extended load data, or an error, through a valid/ready response.

Parameters:
ADDR_W, 6, width of DM address port; beat address = (req_addr + k) mod 2^ADDR_W
SPLIT_MISALIGNED, 1, 1 = split misaligned half/word into byte beats; 0 = misaligned request returns resp_err with no DM access

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw
req_addr  in  32  byte address; only [ADDR_W-1:0] used
req_wdata  in  32  store data (low bytes used per size)
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3, or misaligned with SPLIT_MISALIGNED=0
dm_we  out  1  DM write enable
dm_addr  out  ADDR_W  DM address
dm_din  out  32  DM write data
dm_type  out  3  DM type: 000 word, 001 half, 011 byte
dm_dout  in  32  DM combinational read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rstn=0): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_we=0, dm_addr=0, dm_din=0, dm_type=000, beat counter=0.
  - Reset mid-operation abandons the access immediately; dm_we drops without waiting for a clock edge. No partial response is produced.
- Request capture: on req_valid && req_ready, register we, funct3, addr, wdata.
- Size: funct3[1:0] gives 00 byte, 01 half, 10 word.
- Legality:
  - Illegal: funct3 in {011, 110, 111}, and stores with funct3[2]=1.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- States:
  - IDLE: req_ready=1, dm_we=0.
    - Illegal request, or misaligned with SPLIT_MISALIGNED=0 -> RESP with err=1.
    - Aligned request -> ACCESS.
    - Misaligned request (split enabled) -> SPLIT with k=0.
  - ACCESS: one cycle.
    - dm_addr = addr; dm_type = 011/001/000 for byte/half/word; dm_din = wdata; dm_we = we.
    - Loads capture dm_dout at the clock edge ending the cycle. -> RESP.
  - SPLIT: beat k, with N = 2 (half) or 4 (word).
    - dm_addr = addr+k (wraps mod 2^ADDR_W); dm_type = 011; dm_din = {24'b0, wdata byte k}; dm_we = we.
    - Loads capture dm_dout[7:0] into buffer byte k.
    - k increments each cycle; after beat N-1 -> RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err stay stable until resp_ready. On resp_valid && resp_ready -> IDLE.
    - req_ready stays 0 in the handshake cycle, so the next request is accepted at the earliest one cycle later.
- Load extension:
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
  - Bits above the access size coming from the DM are ignored before extension.
- Latency, request accepted at edge T, resp_ready held high:
  - Aligned: DM beat in cycle T+1; resp_valid from T+2.
  - Misaligned half: beats T+1..T+2; resp_valid from T+3.
  - Misaligned word: beats T+1..T+4; resp_valid from T+5.
  - Error: resp_valid from T+1, with zero DM beats.
- DM-side rules:
  - dm_we is asserted only in ACCESS/SPLIT, exactly one cycle per beat.
  - Each byte is written exactly once per store.
  - Loads never assert dm_we.
- Backpressure: resp_ready low holds RESP indefinitely. No DM activity occurs while in RESP.
- Simultaneous events: req_valid while not IDLE is ignored; the requester holds it.
- Address wrap: word at 2^ADDR_W-2 accesses bytes 62, 63, 0, 1 (ADDR_W=6).

Test Plan:
- Aligned sw 0x8765_4321 @0x08, then lw @0x08 -> one ACCESS beat each with dm_type=000; rdata=0x8765_4321; load resp_valid two cycles after acceptance.
- sb 0xF0 @0x05, then lb @0x05 and lbu @0x05 -> rdata 0xFFFF_FFF0 and 0x0000_00F0; bytes 0x04/0x06 unchanged.
- Misaligned sw 0xAABB_CCDD @0x03 (split on) -> four byte beats, addr 3,4,5,6 with din low bytes DD,CC,BB,AA; lw @0x03 returns 0xAABB_CCDD, resp_valid five cycles after acceptance.
- Misaligned lh @0x3F, bytes 0x3F=0x80 and 0x00=0x01 -> beats at addr 63, 0; rdata 0x0000_0180. Repeat with SPLIT_MISALIGNED=0 -> resp_err=1, no dm_we, rdata 0.
- Illegal funct3 011 load and sbu-style store funct3 100 -> resp_err=1 one cycle after acceptance; zero DM beats.
- Hold resp_ready=0 for 5 cycles, then pulse rstn low mid SPLIT of a store -> resp stable while held; reset drops dm_we and resp_valid immediately, req_ready=1 after release, remaining bytes unwritten.
